// File: rtl/otter_hazard_ctrl.sv
// Hazard and forwarding controller for the 5-stage OTTER pipeline: load-use stalls,
// taken-branch flushes, data-memory freezes, registered EX operand selects and perf counters.
module otter_hazard_ctrl #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [4:0]       ID_rs1,
    input  logic [4:0]       ID_rs2,
    input  logic             ID_rs1_used,
    input  logic             ID_rs2_used,
    input  logic [4:0]       EX_rd,
    input  logic             EX_regWrite,
    input  logic             EX_memRead,
    input  logic [4:0]       MEM_rd,
    input  logic             MEM_regWrite,
    input  logic             EX_br_taken,
    input  logic             MEM_busy,
    output logic             freeze,
    output logic             PC_stall,
    output logic             IF_ID_stall,
    output logic             IF_ID_flush,
    output logic             ID_EX_flush,
    output logic [1:0]       EX_fwdA_SEL,
    output logic [1:0]       EX_fwdB_SEL,
    output logic [1:0]       hz_state,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [1:0]       SEL_RF  = 2'b00;
    localparam logic [1:0]       SEL_MEM = 2'b01;
    localparam logic [1:0]       SEL_WB  = 2'b10;

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        LD_STALL = 2'b01,
        MEM_WAIT = 2'b10
    } hz_state_t;

    hz_state_t  state;
    hz_state_t  state_nxt;
    logic       ldu;
    logic       ld_stall;
    logic       br_flush;
    logic [1:0] fwd_a;
    logic [1:0] fwd_b;

    // Youngest producer wins; x0 is hard-wired zero and never forwards.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] rs,
        input logic       used,
        input logic [4:0] ex_rd,
        input logic       ex_wr,
        input logic [4:0] mem_rd,
        input logic       mem_wr
    );
        logic [1:0] sel;
        sel = SEL_RF;
        if (used && ex_wr && (ex_rd != 5'd0) && (rs == ex_rd)) begin
            sel = SEL_MEM;
        end else if (used && mem_wr && (mem_rd != 5'd0) && (rs == mem_rd)) begin
            sel = SEL_WB;
        end
        return sel;
    endfunction

    // Hazard detection and pipeline control, purely from current inputs.
    always_comb begin
        freeze      = 1'b0;
        PC_stall    = 1'b0;
        IF_ID_stall = 1'b0;
        IF_ID_flush = 1'b0;
        ID_EX_flush = 1'b0;
        ld_stall    = 1'b0;
        br_flush    = 1'b0;
        ldu = EX_memRead && EX_regWrite && (EX_rd != 5'd0) &&
              ((ID_rs1_used && (ID_rs1 == EX_rd)) || (ID_rs2_used && (ID_rs2 == EX_rd)));
        fwd_a = fwd_sel(ID_rs1, ID_rs1_used, EX_rd, EX_regWrite, MEM_rd, MEM_regWrite);
        fwd_b = fwd_sel(ID_rs2, ID_rs2_used, EX_rd, EX_regWrite, MEM_rd, MEM_regWrite);
        if (!RST) begin
            if (MEM_busy) begin
                freeze      = 1'b1;
                PC_stall    = 1'b1;
                IF_ID_stall = 1'b1;
            end else if (EX_br_taken) begin
                br_flush    = 1'b1;
                IF_ID_flush = 1'b1;
                ID_EX_flush = 1'b1;
            end else if (ldu) begin
                ld_stall    = 1'b1;
                PC_stall    = 1'b1;
                IF_ID_stall = 1'b1;
                ID_EX_flush = 1'b1;
            end
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            RUN: begin
                if (MEM_busy) begin
                    state_nxt = MEM_WAIT;
                end else if (ldu && !EX_br_taken) begin
                    state_nxt = LD_STALL;
                end
            end
            LD_STALL: state_nxt = MEM_busy ? MEM_WAIT : RUN;
            MEM_WAIT: state_nxt = MEM_busy ? MEM_WAIT : RUN;
            default:  state_nxt = RUN;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    assign hz_state = state;

    // Operand selects follow the ID instruction into EX unless frozen or bubbled.
    always_ff @(posedge CLK) begin
        if (RST) begin
            EX_fwdA_SEL <= SEL_RF;
            EX_fwdB_SEL <= SEL_RF;
        end else if (freeze) begin
            EX_fwdA_SEL <= EX_fwdA_SEL;
            EX_fwdB_SEL <= EX_fwdB_SEL;
        end else if (ID_EX_flush) begin
            EX_fwdA_SEL <= SEL_RF;
            EX_fwdB_SEL <= SEL_RF;
        end else begin
            EX_fwdA_SEL <= fwd_a;
            EX_fwdB_SEL <= fwd_b;
        end
    end

    // Saturating performance counters.
    always_ff @(posedge CLK) begin
        if (RST) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if ((freeze || PC_stall) && (stall_cnt != CNT_MAX)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (br_flush && (flush_cnt != CNT_MAX)) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
        end
    end

    // The bubble inserted by a load-use stall must clear the hazard on the following cycle.
    ld_stall_once: assert property (@(posedge CLK) disable iff (RST)
        (state == LD_STALL) |-> !ldu);

    logic unused_ok;
    assign unused_ok = ld_stall;

endmodule

// File: tb/tb_otter_hazard_ctrl.sv
// Randomized and directed bench for otter_hazard_ctrl against a cycle-level behavioural model.
module tb_otter_hazard_ctrl;

    logic       CLK = 1'b0;
    logic       RST;
    logic [4:0] ID_rs1, ID_rs2, EX_rd, MEM_rd;
    logic       ID_rs1_used, ID_rs2_used, EX_regWrite, EX_memRead, MEM_regWrite;
    logic       EX_br_taken, MEM_busy;

    logic        freeze, PC_stall, IF_ID_stall, IF_ID_flush, ID_EX_flush;
    logic [1:0]  EX_fwdA_SEL, EX_fwdB_SEL, hz_state;
    logic [15:0] stall_cnt, flush_cnt;
    logic        freeze4, PC_stall4, IF_ID_stall4, IF_ID_flush4, ID_EX_flush4;
    logic [1:0]  fa4, fb4, hz4;
    logic [3:0]  stall_cnt4, flush_cnt4;

    int tests = 0;
    int fails = 0;

    // Model state: expected registered outputs and unsaturated event counts.
    int m_fa, m_fb, m_state, m_stalls, m_flushes;

    always #5 CLK = ~CLK;

    otter_hazard_ctrl u_dut (
        .CLK(CLK), .RST(RST), .ID_rs1(ID_rs1), .ID_rs2(ID_rs2),
        .ID_rs1_used(ID_rs1_used), .ID_rs2_used(ID_rs2_used),
        .EX_rd(EX_rd), .EX_regWrite(EX_regWrite), .EX_memRead(EX_memRead),
        .MEM_rd(MEM_rd), .MEM_regWrite(MEM_regWrite),
        .EX_br_taken(EX_br_taken), .MEM_busy(MEM_busy),
        .freeze(freeze), .PC_stall(PC_stall), .IF_ID_stall(IF_ID_stall),
        .IF_ID_flush(IF_ID_flush), .ID_EX_flush(ID_EX_flush),
        .EX_fwdA_SEL(EX_fwdA_SEL), .EX_fwdB_SEL(EX_fwdB_SEL), .hz_state(hz_state),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    otter_hazard_ctrl #(.CNT_W(4)) u_dut4 (
        .CLK(CLK), .RST(RST), .ID_rs1(ID_rs1), .ID_rs2(ID_rs2),
        .ID_rs1_used(ID_rs1_used), .ID_rs2_used(ID_rs2_used),
        .EX_rd(EX_rd), .EX_regWrite(EX_regWrite), .EX_memRead(EX_memRead),
        .MEM_rd(MEM_rd), .MEM_regWrite(MEM_regWrite),
        .EX_br_taken(EX_br_taken), .MEM_busy(MEM_busy),
        .freeze(freeze4), .PC_stall(PC_stall4), .IF_ID_stall(IF_ID_stall4),
        .IF_ID_flush(IF_ID_flush4), .ID_EX_flush(ID_EX_flush4),
        .EX_fwdA_SEL(fa4), .EX_fwdB_SEL(fb4), .hz_state(hz4),
        .stall_cnt(stall_cnt4), .flush_cnt(flush_cnt4)
    );

    task automatic check(input string tag, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int sat(input int v, input int max);
        return (v > max) ? max : v;
    endfunction

    // Operand select a register read in ID should see in EX next cycle.
    function automatic int want_sel(input int rs, input bit used);
        if (!used || rs == 0) return 0;
        if (EX_regWrite && EX_rd == 5'(rs)) return 1;
        if (MEM_regWrite && MEM_rd == 5'(rs)) return 2;
        return 0;
    endfunction

    task automatic set_in(input int rs1, input bit u1, input int rs2, input bit u2,
                          input int exrd, input bit exwr, input bit exld,
                          input int memrd, input bit memwr, input bit br, input bit busy);
        ID_rs1 = 5'(rs1); ID_rs1_used = u1; ID_rs2 = 5'(rs2); ID_rs2_used = u2;
        EX_rd = 5'(exrd); EX_regWrite = exwr; EX_memRead = exld;
        MEM_rd = 5'(memrd); MEM_regWrite = memwr; EX_br_taken = br; MEM_busy = busy;
    endtask

    // Check the current cycle against the model, advance the model, move to next negedge.
    task automatic tick();
        bit hazard, bubble, kill;
        bit e_frz, e_pcs, e_iff, e_idf;
        #1;
        hazard = EX_memRead && EX_regWrite && EX_rd != 0 &&
                 ((ID_rs1_used && ID_rs1 == EX_rd) || (ID_rs2_used && ID_rs2 == EX_rd));
        kill   = !RST && !MEM_busy && EX_br_taken;
        bubble = !RST && !MEM_busy && !EX_br_taken && hazard;
        e_frz  = !RST && MEM_busy;
        e_pcs  = e_frz || bubble;
        e_iff  = kill;
        e_idf  = kill || bubble;
        check("freeze", int'(freeze), int'(e_frz));
        check("PC_stall", int'(PC_stall), int'(e_pcs));
        check("IF_ID_stall", int'(IF_ID_stall), int'(e_pcs));
        check("IF_ID_flush", int'(IF_ID_flush), int'(e_iff));
        check("ID_EX_flush", int'(ID_EX_flush), int'(e_idf));
        check("fwdA", int'(EX_fwdA_SEL), m_fa);
        check("fwdB", int'(EX_fwdB_SEL), m_fb);
        check("hz_state", int'(hz_state), m_state);
        check("stall_cnt", int'(stall_cnt), sat(m_stalls, 65535));
        check("flush_cnt", int'(flush_cnt), sat(m_flushes, 65535));
        check("stall_cnt4", int'(stall_cnt4), sat(m_stalls, 15));
        check("flush_cnt4", int'(flush_cnt4), sat(m_flushes, 15));
        if (RST) begin
            m_fa = 0; m_fb = 0; m_state = 0; m_stalls = 0; m_flushes = 0;
        end else begin
            if (!e_frz) begin
                m_fa = e_idf ? 0 : want_sel(int'(ID_rs1), ID_rs1_used);
                m_fb = e_idf ? 0 : want_sel(int'(ID_rs2), ID_rs2_used);
            end
            if (MEM_busy)                     m_state = 2;
            else if (m_state == 0 && bubble)  m_state = 1;
            else                              m_state = 0;
            if (e_pcs) m_stalls++;
            if (kill)  m_flushes++;
        end
        @(negedge CLK);
    endtask

    task automatic do_reset();
        RST = 1'b1;
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        tick();
        RST = 1'b0;
    endtask

    initial begin
        m_fa = 0; m_fb = 0; m_state = 0; m_stalls = 0; m_flushes = 0;
        RST = 1'b1;
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge CLK);
        do_reset();
        check("rst_state", int'(hz_state), 0);
        check("rst_cnt", int'(stall_cnt), 0);

        // ADD x5 in EX, ID reads rs2=x5.
        set_in(1, 0, 5, 1, 5, 1, 0, 0, 0, 0, 0);
        #1 check("add_nostall", int'(PC_stall), 0);
        tick();
        check("add_fwdB", int'(EX_fwdB_SEL), 1);

        // LW x6 in EX, ID reads rs1=x6: one stall, then WB forward.
        do_reset();
        set_in(6, 1, 0, 0, 6, 1, 1, 0, 0, 0, 0);
        #1 check("lw_pcstall", int'(PC_stall), 1);
        check("lw_idexflush", int'(ID_EX_flush), 1);
        tick();
        check("lw_state1", int'(hz_state), 1);
        check("lw_bubble", int'(EX_fwdA_SEL), 0);
        check("lw_cnt", int'(stall_cnt), 1);
        set_in(6, 1, 0, 0, 0, 0, 0, 6, 1, 0, 0);
        #1 check("lw_nostall", int'(PC_stall), 0);
        tick();
        check("lw_state0", int'(hz_state), 0);
        check("lw_fwdWB", int'(EX_fwdA_SEL), 2);

        // EX and MEM both write x7: EX wins; x0 never forwards.
        set_in(7, 1, 0, 1, 7, 1, 0, 7, 1, 0, 0);
        tick();
        check("exbeatsmem", int'(EX_fwdA_SEL), 1);
        check("x0_rs2", int'(EX_fwdB_SEL), 0);
        set_in(0, 1, 0, 1, 0, 1, 0, 0, 1, 0, 0);
        tick();
        check("x0_fwd", int'(EX_fwdA_SEL), 0);

        // Taken branch with simultaneous load-use.
        do_reset();
        set_in(3, 1, 0, 0, 3, 1, 1, 0, 0, 1, 0);
        #1 check("br_pcstall", int'(PC_stall), 0);
        check("br_ifflush", int'(IF_ID_flush), 1);
        tick();
        check("br_flushcnt", int'(flush_cnt), 1);

        // MEM_busy for 3 cycles during a taken branch.
        do_reset();
        set_in(2, 1, 0, 0, 2, 1, 0, 0, 0, 0, 0);
        tick();
        set_in(2, 1, 2, 1, 0, 0, 0, 2, 1, 1, 1);
        for (int i = 0; i < 3; i++) begin
            #1 check("busy_noflush", int'(IF_ID_flush), 0);
            tick();
            check("busy_state", int'(hz_state), 2);
            check("busy_hold", int'(EX_fwdA_SEL), 1);
        end
        MEM_busy = 1'b0;
        #1 check("busy_flush4", int'(IF_ID_flush), 1);
        tick();
        check("busy_stallcnt", int'(stall_cnt), 3);
        check("busy_state0", int'(hz_state), 0);

        // 20 freeze cycles saturate the 4-bit counter; reset mid-wait clears everything.
        do_reset();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 20; i++) tick();
        check("sat16", int'(stall_cnt), 20);
        check("sat4", int'(stall_cnt4), 15);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        MEM_busy = 1'b0;
        check("rst_mid_state", int'(hz_state), 0);
        check("rst_mid_cnt", int'(stall_cnt4), 0);
        #1 check("rst_mid_nostall", int'(PC_stall), 0);

        // Random traffic over a small register set to provoke matches.
        for (int i = 0; i < 3000; i++) begin
            RST          = ($urandom_range(99) < 2);
            ID_rs1       = 5'($urandom_range(3));
            ID_rs2       = 5'($urandom_range(3));
            ID_rs1_used  = 1'($urandom_range(1));
            ID_rs2_used  = 1'($urandom_range(1));
            EX_rd        = 5'($urandom_range(3));
            EX_regWrite  = ($urandom_range(99) < 70);
            EX_memRead   = ($urandom_range(99) < 35) && (m_state != 1);
            MEM_rd       = 5'($urandom_range(3));
            MEM_regWrite = ($urandom_range(99) < 70);
            EX_br_taken  = ($urandom_range(99) < 12);
            MEM_busy     = ($urandom_range(99) < 15);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
